// File: rtl/ram_host_pkg.sv
// Shared constants, state encoding and helpers for the operand-RAM host port.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ram_host_pkg;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 198;   // 99 trits x 2 bits
  localparam int BEAT_W    = 32;
  localparam int BEATS     = (DATA_W + BEAT_W - 1) / BEAT_W;   // 7
  localparam int LAST_BITS = DATA_W - (BEATS - 1) * BEAT_W;    // 6
  localparam int BCNT_W    = 3;

  typedef logic [BCNT_W-1:0] beat_cnt_t;

  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WCOLLECT = 3'd1,
    ST_WCOMMIT  = 3'd2,
    ST_RISSUE   = 3'd3,
    ST_RCAPTURE = 3'd4,
    ST_RSEND    = 3'd5
  } state_t;

  // Bit offset of beat k inside the full-width word.
  function automatic logic [7:0] beat_lsb(input beat_cnt_t k);
    return 8'(k) * 8'(BEAT_W);
  endfunction

endpackage

// File: rtl/beat_shift_reg.sv
// Full-width assembly/disassembly register: parallel load, beat insert at index k, right shift by one beat.
// Latency: register updates at the clock edge; o_nxt shows the value it will take at that edge.
// Backpressure: none; the caller gates i_ins/i_shift with its own handshakes.
//
// Ports: clk/reset_n clock and async active-low reset; i_load/i_load_dat parallel load;
// i_ins/i_ins_idx/i_ins_dat beat insert; i_shift right shift; o_nxt next value; o_beat low beat.
// Priority when several controls are high: load, then insert, then shift.
module beat_shift_reg
  import ram_host_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_dat,
  input  logic              i_ins,
  input  beat_cnt_t         i_ins_idx,
  input  logic [BEAT_W-1:0] i_ins_dat,
  input  logic              i_shift,
  output logic [DATA_W-1:0] o_nxt,
  output logic [BEAT_W-1:0] o_beat
);

  logic [DATA_W-1:0] r_dat;
  logic [DATA_W-1:0] w_lane_mask;
  logic [DATA_W-1:0] w_lane_dat;
  logic [DATA_W-1:0] w_nxt;

  // Shifting past DATA_W truncates the top beat to LAST_BITS, so beat 6
  // only lands wdata[5:0] in bits [197:192].
  always_comb begin
    w_lane_mask = {{(DATA_W-BEAT_W){1'b0}}, {BEAT_W{1'b1}}} << beat_lsb(i_ins_idx);
    w_lane_dat  = {{(DATA_W-BEAT_W){1'b0}}, i_ins_dat}     << beat_lsb(i_ins_idx);
    w_nxt       = r_dat;
    if (i_load) begin
      w_nxt = i_load_dat;
    end else if (i_ins) begin
      w_nxt = (r_dat & ~w_lane_mask) | (w_lane_dat & w_lane_mask);
    end else if (i_shift) begin
      // Zero fill makes the final read beat come out zero-extended.
      w_nxt = r_dat >> BEAT_W;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dat <= '0;
    end else begin
      r_dat <= w_nxt;
    end
  end

  assign o_nxt  = w_nxt;
  assign o_beat = r_dat[BEAT_W-1:0];

endmodule

// File: rtl/ram_host_port.sv
// Host access port for RAM port B: 7 x 32-bit beats <-> one 198-bit RAM word.
// Latency: write strobe 7 edges after command accept; first read beat valid 2 edges after accept.
// Backpressure: valid/ready on cmd, wdata and rdata; rdata/rdata_last hold while rdata_ready is low.
//
// Ports: clk, reset_n (async active-low);
//   cmd_valid/cmd_ready/cmd_write/cmd_addr  host command (one word read or write);
//   wdata/wdata_valid/wdata_ready           write beats, least-significant first;
//   rdata/rdata_valid/rdata_ready/rdata_last read beats, least-significant first, last = beat 6;
//   ram_wr/ram_addr/ram_din/ram_dout        RAM port B (registered read data);
//   busy                                    high whenever not IDLE.
module ram_host_port
  import ram_host_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [BEAT_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [BEAT_W-1:0] rdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic              rdata_last,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  state_t            r_state;
  beat_cnt_t         r_beat;
  logic              r_ram_wr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic              r_rdata_valid;
  logic              r_rdata_last;

  logic              w_load;
  logic              w_ins;
  logic              w_shift;
  logic [DATA_W-1:0] w_sreg_nxt;
  logic [BEAT_W-1:0] w_sreg_beat;

  assign w_load  = (r_state == ST_RCAPTURE);
  assign w_ins   = (r_state == ST_WCOLLECT) && wdata_valid;
  assign w_shift = (r_state == ST_RSEND) && rdata_ready;

  beat_shift_reg u_sreg (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_dat (ram_dout),
    .i_ins      (w_ins),
    .i_ins_idx  (r_beat),
    .i_ins_dat  (wdata),
    .i_shift    (w_shift),
    .o_nxt      (w_sreg_nxt),
    .o_beat     (w_sreg_beat)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_beat        <= '0;
      r_ram_wr      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_din     <= '0;
      r_rdata_valid <= 1'b0;
      r_rdata_last  <= 1'b0;
    end else begin
      r_ram_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_ram_addr <= cmd_addr;
            r_beat     <= '0;
            r_state    <= cmd_write ? ST_WCOLLECT : ST_RISSUE;
          end
        end
        ST_WCOLLECT: begin
          if (wdata_valid) begin
            if (r_beat == LAST_BEAT) begin
              // Snapshot the word including this final beat, so ram_din
              // stays put while later reads reuse the shift register.
              r_ram_din <= w_sreg_nxt;
              r_ram_wr  <= 1'b1;
              r_state   <= ST_WCOMMIT;
            end else begin
              r_beat <= r_beat + beat_cnt_t'(1);
            end
          end
        end
        ST_WCOMMIT: begin
          r_state <= ST_IDLE;
        end
        ST_RISSUE: begin
          // RAM samples ram_addr at the end of this cycle.
          r_state <= ST_RCAPTURE;
        end
        ST_RCAPTURE: begin
          r_beat        <= '0;
          r_rdata_valid <= 1'b1;
          r_rdata_last  <= 1'b0;
          r_state       <= ST_RSEND;
        end
        ST_RSEND: begin
          if (rdata_ready) begin
            if (r_beat == LAST_BEAT) begin
              r_rdata_valid <= 1'b0;
              r_rdata_last  <= 1'b0;
              r_state       <= ST_IDLE;
            end else begin
              r_beat       <= r_beat + beat_cnt_t'(1);
              r_rdata_last <= (r_beat == LAST_BEAT - beat_cnt_t'(1));
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign wdata_ready = (r_state == ST_WCOLLECT);
  assign busy        = (r_state != ST_IDLE);
  assign ram_wr      = r_ram_wr;
  assign ram_addr    = r_ram_addr;
  assign ram_din     = r_ram_din;
  assign rdata       = w_sreg_beat;
  assign rdata_valid = r_rdata_valid;
  assign rdata_last  = r_rdata_last;

endmodule

// File: doc/ram_host_port.md
# ram_host_port

Initiator-side access port for the 198-bit × 128-word dual-port operand RAM of the GF(3^m) pairing core. It converts a narrow 32-bit host stream into full-width RAM accesses on one RAM port. It assembles 7 beats into one 198-bit word and commits it with a single write strobe. For reads, it issues the address, captures the registered RAM output and streams it back as 7 beats. It sits between the host/debug bus and RAM port B while the pairing engine owns port A.

## Interface
- ADDR_W, 7, RAM word address width
- DATA_W, 198, RAM word width (99 trits × 2 bits)
- BEAT_W, 32, host beat width; BEATS = ceil(DATA_W/BEAT_W) = 7

- clk  in  1  rising-edge clock shared with the RAM
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_write  in  1  1 = write word, 0 = read word
- cmd_addr  in  ADDR_W  target RAM word address
- wdata  in  BEAT_W  write beat, least-significant beat first
- wdata_valid  in  1  write beat present
- wdata_ready  out  1  write beat accepted when high with wdata_valid
- rdata  out  BEAT_W  read beat, least-significant beat first
- rdata_valid  out  1  read beat present
- rdata_ready  in  1  host consumes the read beat
- rdata_last  out  1  high with beat 6
- ram_wr  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, valid one clock after the address is presented
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, WCOLLECT, WCOMMIT, RISSUE, RCAPTURE, RSEND.
- IDLE:
  - cmd_ready = 1; wdata_ready = 0.
  - When cmd_valid is high, latch cmd_addr into ram_addr, clear the beat counter, and move to WCOLLECT if cmd_write is 1, otherwise to RISSUE.
- WCOLLECT:
  - wdata_ready = 1.
  - Beat k (0..5) loads bits [32k+31:32k] of the assembly register.
  - Beat 6 loads bits [197:192] from wdata[5:0]; wdata[31:6] are ignored.
  - After beat 6 is accepted, go to WCOMMIT.
- WCOMMIT: ram_wr = 1 for exactly this one cycle with ram_din = the assembled word; then go to IDLE.
- RISSUE: ram_addr is stable; the RAM registers its output at the end of this cycle.
- RCAPTURE: load ram_dout into the shift register; go to RSEND.
- RSEND:
  - rdata = shift register bits [31:0], rdata_valid = 1.
  - On each rdata_ready, shift right by 32 and increment the counter.
  - Beat 6 carries bits [197:192] in rdata[5:0], zero-extended, with rdata_last = 1.
  - After beat 6 is consumed, go to IDLE.
- ram_addr holds its last latched value in IDLE; ram_din holds its last value.
- Handshake rules:
  - Stall: while rdata_valid && !rdata_ready, rdata and rdata_last hold stable.
  - Commands presented while busy stay pending; cmd_ready = 0.
  - wdata_valid outside WCOLLECT is ignored, with no side effect.
- Address range: the full range 0..127 is valid and there is no wrap or bounds logic. Address 127 behaves like any other address.

## Timing
- Reset values (asynchronous, while reset_n = 0):
  - state = IDLE; ram_wr = 0; ram_addr = 0; ram_din = 0.
  - rdata = 0; rdata_valid = 0; rdata_last = 0; beat counter = 0; busy = 0.
- cmd_ready and wdata_ready are decoded combinationally from the state. rdata_valid and rdata_last are registered.
- Write latency: with wdata_valid held high, the command is accepted at edge N, beats are accepted at edges N+1..N+7, and ram_wr is high between edges N+7 and N+8. cmd_ready returns at edge N+8.
- Read latency: with the command accepted at edge N, rdata_valid rises after edge N+2. With rdata_ready held high, the last beat is consumed at edge N+9 and cmd_ready returns after that edge.
- Reset asserted mid-operation aborts immediately:
  - no ram_wr pulse is issued and the partial word is discarded;
  - no further rdata beats are sent.
- Back-to-back commands: the minimum IDLE dwell is one cycle between commands.

## Structure
- The shared package ram_host_pkg holds:
  - ADDR_W, DATA_W, BEAT_W, BEATS = 7, LAST_BITS = 6;
  - state encodings;
  - beat-counter width (3 bits).
- One natural sub-module, beat_shift_reg, used by both directions:
  - a DATA_W-wide register with parallel load (RCAPTURE);
  - a 32-bit beat insert at index k (WCOLLECT);
  - a right-shift by BEAT_W (RSEND).

## Test plan
- Reset check: drive reset_n low mid-clock. All outputs go to their reset values asynchronously, and cmd_ready = 1 after release.
- Write at address 5, beats 0x00000001..0x00000007 with beat 6 = 0xFFFFFFC7:
  - exactly one ram_wr cycle at ram_addr = 5;
  - ram_din[197:192] = 6'h07; ram_din[31:0] = 1.
- Read at address 127 with the RAM model returning 198'h2A…A5:
  - 7 beats; rdata_last only on beat 6;
  - beat 6 upper 26 bits = 0;
  - first rdata_valid 3 cycles after the command is accepted.
- Read with rdata_ready toggled 1-0-0-1: rdata is held stable during the stall and no beat is dropped or duplicated.
- Write then read-back at address 0, repeated for 20 random words on a behavioural 128×198 synchronous RAM: read data equals write data.
- Reset asserted after write beat 3: no ram_wr ever pulses, and a following read returns the old contents.
